// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: parses a length/data/checksum byte frame from the host
// link, writes big-endian words to IM from index 0, and holds the CPU in reset until verified.
module im_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [23:0]         word_q, word_d;
    logic [7:0]          xor_q, xor_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                cpurst_q, cpurst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic [31:0]         word_sh;
    logic [15:0]         n_full;

    assign accept  = in_valid & ready_q;
    assign word_sh = {word_q, in_data};
    assign n_full  = {len_q[15:8], in_data};

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        bcnt_d   = bcnt_q;
        word_d   = word_q;
        xor_d    = xor_q;
        words_d  = words_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    len_d   = 16'd0;
                    bcnt_d  = 2'd0;
                    word_d  = 24'd0;
                    xor_d   = 8'd0;
                    words_d = '0;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d   = {in_data, len_q[7:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = n_full;
                    if ({1'b0, n_full} > MAX_N)
                        state_d = S_ERROR;
                    else if (n_full == 16'd0)
                        state_d = S_CSUM;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d = word_sh[23:0];
                    xor_d  = xor_q ^ in_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = words_q[ADDR_W-1:0];
                        wdata_d = word_sh;
                        words_d = words_q + (ADDR_W+1)'(1);
                        if (16'(words_q) + 16'd1 == len_q)
                            state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept)
                    state_d = (in_data == xor_q) ? S_DONE : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                   (state_d == S_DATA)   || (state_d == S_CSUM);
        cpurst_d = (state_d != S_DONE);
        done_d   = (state_d == S_DONE);
        err_d    = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_q    <= 16'd0;
            bcnt_q   <= 2'd0;
            word_q   <= 24'd0;
            xor_q    <= 8'd0;
            words_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            ready_q  <= 1'b0;
            cpurst_q <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            bcnt_q   <= bcnt_d;
            word_q   <= word_d;
            xor_q    <= xor_d;
            words_q  <= words_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            cpurst_q <= cpurst_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign in_ready     = ready_q;
    assign im_we        = we_q;
    assign im_addr      = addr_q;
    assign im_wdata     = wdata_q;
    assign cpu_reset    = cpurst_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: frames with hand-computed checksums, write log and latency checks.
module tb_im_loader;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset, start, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, im_we, cpu_reset, done, err;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic [ADDR_W:0]   words_loaded;

    im_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_reset(cpu_reset), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int consec = 0;
    logic prev_we = 1'b0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          acc_hist[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (im_we) begin
            wr_addr.push_back(32'(im_addr));
            wr_data.push_back(im_wdata);
            wr_cyc.push_back(cyc);
            if (prev_we) consec <= consec + 1;
        end
        prev_we <= im_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap, output bit ok);
        bit rdy;
        ok = 1'b0;
        repeat (gap) @(negedge clk);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            rdy      = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                acc_hist.push_back(cyc);
            end
            in_valid = 1'b0;
        end
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input int maxgap);
        bit ok;
        foreach (q[i]) begin
            send(q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, ok);
            n_vec++;
            assert (ok) else begin
                n_err++;
                $error("FAIL accept: observed timeout expected byte %h taken", q[i]);
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); acc_hist.delete();
    endtask

    initial begin
        logic [7:0] fr[$];
        bit ok;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready",  32'(in_ready),     32'd0);
        chk("rst_cpurst", 32'(cpu_reset),    32'd1);
        chk("rst_done",   32'(done),         32'd0);
        chk("rst_err",    32'(err),          32'd0);
        chk("rst_we",     32'(im_we),        32'd0);
        chk("rst_addr",   32'(im_addr),      32'd0);
        chk("rst_wdata",  im_wdata,          32'd0);
        chk("rst_words",  32'(words_loaded), 32'd0);

        // N=2; XOR of the eight data bytes is 0x76
        clear_log(); pulse_start();
        fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h01, 8'hAB, 8'hCD, 8'h76};
        send_bytes(fr, 0);
        @(negedge clk);
        chk("t1_nwr",   32'(wr_addr.size()), 32'd2);
        chk("t1_a0",    wr_addr[0], 32'd0);
        chk("t1_d0",    wr_data[0], 32'h20080005);
        chk("t1_a1",    wr_addr[1], 32'd1);
        chk("t1_d1",    wr_data[1], 32'h3C01ABCD);
        chk("t1_lat0",  32'(wr_cyc[0]), 32'(acc_hist[5]));
        chk("t1_lat1",  32'(wr_cyc[1]), 32'(acc_hist[9]));
        chk("t1_done",  32'(done), 32'd1);
        chk("t1_cpurst",32'(cpu_reset), 32'd0);
        chk("t1_words", 32'(words_loaded), 32'd2);

        // N=1 with wrong checksum (correct is 0x08)
        clear_log(); pulse_start();
        fr = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
        send_bytes(fr, 0);
        @(negedge clk);
        chk("t2_nwr",   32'(wr_addr.size()), 32'd1);
        chk("t2_d0",    wr_data[0], 32'h12345678);
        chk("t2_err",   32'(err), 32'd1);
        chk("t2_cpurst",32'(cpu_reset), 32'd1);
        chk("t2_done",  32'(done), 32'd0);

        // Oversize length 0x0401
        clear_log(); pulse_start();
        fr = '{8'h04, 8'h01};
        send_bytes(fr, 0);
        @(negedge clk);
        chk("t3_err",   32'(err), 32'd1);
        chk("t3_ready", 32'(in_ready), 32'd0);
        send(8'hAA, 0, ok);
        chk("t3_noacc", 32'(ok), 32'd0);
        chk("t3_nwr",   32'(wr_addr.size()), 32'd0);

        // Empty image, good and bad checksum
        clear_log(); pulse_start();
        fr = '{8'h00, 8'h00, 8'h00};
        send_bytes(fr, 0);
        @(negedge clk);
        chk("t4_done",  32'(done), 32'd1);
        chk("t4_words", 32'(words_loaded), 32'd0);
        chk("t4_nwr",   32'(wr_addr.size()), 32'd0);
        pulse_start();
        fr = '{8'h00, 8'h00, 8'h01};
        send_bytes(fr, 0);
        @(negedge clk);
        chk("t4_err",   32'(err), 32'd1);

        // N=3 with random valid gaps; XOR of data bytes is 0xCC
        clear_log(); pulse_start();
        fr = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
               8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCC};
        send_bytes(fr, 3);
        @(negedge clk);
        chk("t5_nwr",   32'(wr_addr.size()), 32'd3);
        chk("t5_d0",    wr_data[0], 32'h11223344);
        chk("t5_d1",    wr_data[1], 32'h55667788);
        chk("t5_a2",    wr_addr[2], 32'd2);
        chk("t5_d2",    wr_data[2], 32'h99AABBCC);
        chk("t5_lat0",  32'(wr_cyc[0]), 32'(acc_hist[5]));
        chk("t5_lat1",  32'(wr_cyc[1]), 32'(acc_hist[9]));
        chk("t5_lat2",  32'(wr_cyc[2]), 32'(acc_hist[13]));
        chk("t5_done",  32'(done), 32'd1);

        // Reset after the 6th data byte aborts the load
        clear_log(); pulse_start();
        fr = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_bytes(fr, 2);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("t5r_nwr",   32'(wr_addr.size()), 32'd1);
        chk("t5r_d0",    wr_data[0], 32'h11223344);
        chk("t5r_cpurst",32'(cpu_reset), 32'd1);
        chk("t5r_ready", 32'(in_ready), 32'd0);
        chk("t5r_words", 32'(words_loaded), 32'd0);
        chk("t5r_done",  32'(done), 32'd0);

        // Reach DONE, then restart: cpu_reset must rise on entry to LEN_HI
        clear_log(); pulse_start();
        fr = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_bytes(fr, 0);
        @(negedge clk);
        chk("t6_done0", 32'(cpu_reset), 32'd0);
        pulse_start();
        chk("t6_cpurst",32'(cpu_reset), 32'd1);
        chk("t6_words", 32'(words_loaded), 32'd0);
        clear_log();
        fr = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        send_bytes(fr, 0);
        @(negedge clk);
        chk("t6_d0",    wr_data[0], 32'hFFFFFFFF);
        chk("t6_done",  32'(done), 32'd1);

        // Full-depth image N=1024, word k = k; the data XOR cancels to 0x00
        clear_log(); pulse_start();
        fr = '{8'h04, 8'h00};
        for (int k = 0; k < 1024; k++) begin
            fr.push_back(8'h00); fr.push_back(8'h00);
            fr.push_back(8'(k >> 8)); fr.push_back(8'(k));
        end
        fr.push_back(8'h00);
        send_bytes(fr, 0);
        @(negedge clk);
        chk("full_nwr",   32'(wr_addr.size()), 32'd1024);
        chk("full_alast", wr_addr[1023], 32'h3FF);
        chk("full_dlast", wr_data[1023], 32'h000003FF);
        chk("full_d512",  wr_data[512],  32'h00000200);
        chk("full_words", 32'(words_loaded), 32'd1024);
        chk("full_done",  32'(done), 32'd1);
        chk("no_consec_we", 32'(consec), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
